// File: rtl/modulo_subtraction.sv
// Three-stage pipelined modulo-2^WIDTH subtractor with valid/ready flow control
// and a sideband tag. Inverse of the SNOW 2.0 pipelined modulo adder.
module modulo_subtraction #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned DW = WIDTH + 1;

    logic             adv;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;
    logic [DW-1:0]    s2_diff;
    logic [TAG_W-1:0] s2_tag;
    logic [DW-1:0]    s1_diff_c;

    // Global enable: every stage moves together unless the output is stalled.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Zero-extended subtraction; the extra MSB is the borrow out.
    always_comb begin
        s1_diff_c = {1'b0, s1_a} - {1'b0, s1_b};
    end

    // S1: operand capture; a bubble enters when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_a     <= a;
            s1_b     <= b;
            s1_tag   <= in_tag;
        end
    end

    // S2: registered {borrow, diff}.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_diff  <= '0;
            s2_tag   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_diff  <= s1_diff_c;
            s2_tag   <= s1_tag;
        end
    end

    // S3: output register, held stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            diff      <= s2_diff[WIDTH-1:0];
            borrow    <= s2_diff[DW-1];
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_modulo_subtraction.sv
// Self-checking bench for modulo_subtraction: directed cases with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_modulo_subtraction;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             br;
        logic [TAG_W-1:0] t;
        int               acc;
    } exp_t;

    exp_t q[$];
    int   adv_cnt = 0;

    modulo_subtraction #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic [TAG_W-1:0] tv);
        in_valid = v;
        a        = av;
        b        = bv;
        in_tag   = tv;
    endtask

    // Reference model: inputs/outputs are stable between the mid-cycle negedge
    // and the next posedge, so the negedge sees exactly what the edge will act on.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] held_d;
    logic             held_br;
    logic [TAG_W-1:0] held_t;

    always @(negedge clk) begin
        logic exp_adv;
        exp_t e;
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            exp_adv = !out_valid || out_ready;
            chk("in_ready", 64'(in_ready), 64'(exp_adv));
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_diff", 64'(diff), 64'(held_d));
                chk("hold_borrow", 64'(borrow), 64'(held_br));
                chk("hold_tag", 64'(out_tag), 64'(held_t));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("sb_diff", 64'(diff), 64'(e.d));
                    chk("sb_borrow", 64'(borrow), 64'(e.br));
                    chk("sb_tag", 64'(out_tag), 64'(e.t));
                    chk("sb_latency", 64'(adv_cnt - e.acc), 64'(2));
                end
            end
            if (exp_adv) adv_cnt++;
            if (in_valid && in_ready) begin
                e.d   = a - b;
                e.br  = (a < b);
                e.t   = in_tag;
                e.acc = adv_cnt;
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            held_d     = diff;
            held_br    = borrow;
            held_t     = out_tag;
        end
    end

    initial begin
        logic [WIDTH-1:0] sd;

        // Reset state
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_diff", 64'(diff), 64'(0));
        chk("rst_borrow", 64'(borrow), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Basic: 5 - 3, three cycles of latency, single-cycle valid
        out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd3, 4'd1);
        step();
        drive(1'b0, '0, '0, '0);
        step();
        chk("basic_early", 64'(out_valid), 64'(0));
        step();
        chk("basic_valid", 64'(out_valid), 64'(1));
        chk("basic_diff", 64'(diff), 64'(2));
        chk("basic_borrow", 64'(borrow), 64'(0));
        chk("basic_tag", 64'(out_tag), 64'(1));
        step();
        chk("basic_once", 64'(out_valid), 64'(0));

        // Wrap-around and equal operands
        drive(1'b1, 32'h0000_0000, 32'h0000_0001, 4'd2);
        step();
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd3);
        step();
        drive(1'b0, '0, '0, '0);
        step();
        chk("wrap_diff", 64'(diff), 64'h0000_0000_FFFF_FFFF);
        chk("wrap_borrow", 64'(borrow), 64'(1));
        chk("wrap_tag", 64'(out_tag), 64'(2));
        step();
        chk("eq_diff", 64'(diff), 64'(0));
        chk("eq_borrow", 64'(borrow), 64'(0));
        chk("eq_tag", 64'(out_tag), 64'(3));
        step();
        chk("wrap_idle", 64'(out_valid), 64'(0));

        // Streaming: 8 back-to-back ops, all differences 0x10
        for (int i = 0; i <= 10; i++) begin
            if (i < 8) drive(1'b1, WIDTH'(32'h10 + i), WIDTH'(i), TAG_W'(i));
            else       drive(1'b0, '0, '0, '0);
            step();
            if (i >= 2 && i <= 9) begin
                chk("stream_valid", 64'(out_valid), 64'(1));
                chk("stream_diff", 64'(diff), 64'h10);
                chk("stream_tag", 64'(out_tag), 64'(i - 2));
            end
        end
        chk("stream_end", 64'(out_valid), 64'(0));

        // Backpressure: fill pipe, stall 5 cycles, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, $urandom, TAG_W'(4 + i));
            step();
        end
        out_ready = 1'b0;
        drive(1'b1, $urandom, $urandom, 4'hF);
        #1;
        sd = diff;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_tag", 64'(out_tag), 64'(5));
            chk("bp_diff", 64'(diff), 64'(sd));
            step();
            drive(1'b1, $urandom, $urandom, 4'hF);
        end
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0);
        #1;
        chk("bp_release_tag", 64'(out_tag), 64'(5));
        step();
        chk("bp_drain_tag6", 64'(out_tag), 64'(6));
        step();
        chk("bp_drain_tag7", 64'(out_tag), 64'(7));
        step();
        chk("bp_drain_end", 64'(out_valid), 64'(0));

        // Reset mid-operation: two accepted ops must vanish
        drive(1'b1, 32'd100, 32'd1, 4'd9);
        step();
        drive(1'b1, 32'd200, 32'd2, 4'd10);
        step();
        drive(1'b0, '0, '0, '0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_diff", 64'(diff), 64'(0));
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mid_rst_no_out", 64'(out_valid), 64'(0));
        end

        // Random traffic against the scoreboard
        for (int n = 0; n < 1000; n++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
            drive(($urandom_range(0, 3) != 0), ra, rb, TAG_W'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (q.size() != 0 || out_valid); k++) step();
        chk("drain_empty", 64'(q.size()), 64'(0));
        chk("drain_idle", 64'(out_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modulo_subtraction.md
Name: modulo_subtraction

Overview:
- Pipelined modulo-2^WIDTH subtractor for the SNOW 2.0 datapath. It is the inverse of the existing pipelined modulo adder.
- Computes diff = (a - b) mod 2^WIDTH, e.g. to recover s15 from the FSM word or to undo an R1/R2 addition during self-check.
- Three register stages with valid/ready flow control and a sideband tag, so results can be matched to requests under backpressure.

Parameters:
- WIDTH, 32, operand/result width; modulus is 2^WIDTH.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair on a/b/in_tag is valid.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  output  1  diff/borrow/out_tag valid.
- out_ready  input  1  downstream accepts the result this cycle.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow  output  1  1 when a < b as unsigned, i.e. wrap-around occurred.
- out_tag  output  TAG_W  tag of the operation at the output.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Sampled only on the rising edge of clk.
- Reset clears all stage valid bits, diff, borrow and out_tag to 0. in_ready is 1 in the first cycle after reset.
- Stages:
  - S1 registers a, b and tag.
  - S2 registers the WIDTH+1-bit difference {borrow, diff} = {1'b0,a} - {1'b0,b}, plus the tag.
  - S3 is the output register.
- Arithmetic:
  - Result is the low WIDTH bits of the difference; no division or modulo operator.
  - borrow = MSB of the WIDTH+1-bit result.
  - a == b gives diff 0, borrow 0.
- Pipeline advance: adv = !out_valid || out_ready. When adv = 1, all stages shift by one and S1 loads from the inputs.
- Handshakes:
  - in_ready = adv, combinational from out_valid and out_ready.
  - An input is accepted on a cycle where in_valid && in_ready; a bubble (valid 0) enters S1 otherwise.
  - An output transfer is a cycle where out_valid && out_ready.
- Latency:
  - Exactly 3 cycles from acceptance to out_valid, with no backpressure.
  - Throughput is 1 result per cycle when out_ready is held high.
- Backpressure:
  - While out_valid && !out_ready, all stages hold and diff/borrow/out_tag stay stable.
  - in_ready = 0, and inputs presented with in_ready = 0 are ignored.
- Bubbles: they propagate and do not compress while stalled. This simple global-enable pipeline is deliberate.
- Simultaneous events: an output transfer and an input acceptance in the same cycle are both legal. The pipeline shifts once.
- Reset mid-operation: all in-flight operations are discarded. No out_valid is asserted for operations accepted before reset.
- Ordering: results leave in acceptance order, and the tag is carried bit-exact.
- out_valid deasserts only after a transfer, or on reset.

Test Plan:
- Basic: a=5, b=3, tag=1, out_ready=1 -> 3 cycles later diff=2, borrow=0, out_tag=1, out_valid high for 1 cycle.
- Wrap-around: a=0, b=1 -> diff=0xFFFFFFFF, borrow=1. Also a=0x80000000, b=0x80000000 -> diff=0, borrow=0.
- Streaming: 8 back-to-back ops, tags 0..7, b=i, a=0x10+i, out_ready=1 -> 8 consecutive out_valid cycles, all diff=0x10, tags 0..7 in order.
- Backpressure:
  - Stream 4 ops, then drop out_ready for 5 cycles -> outputs hold stable and in_ready=0 throughout.
  - On release, remaining results emerge in order with no loss or duplication.
- Reset mid-operation: accept 2 ops, assert rst for 1 cycle on the next edge -> out_valid=0 and diff=0 after reset, and neither op appears.
- Random cross-check: 1000 random a/b/tag with random in_valid/out_ready -> scoreboard matches (a-b) mod 2^32 and a<b for every transfer, in order.
